// File: rtl/johnson_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : johnson_seq_ctrl_if
// Purpose  : Command/status bundle for the Johnson ring sequencer.
//            The master drives the commands and the slave returns the
//            ring pattern and status flags.
// Signals  : start/stop/step  - run control (level sampled)
//            dir              - 0 forward, 1 reverse
//            rate             - prescaler compare value (period = rate+1)
//            load/load_val    - parallel load of a ring pattern
//            ring/phase       - ring state and its position 0..2W-1
//            busy/wrap        - running flag, wrap-around pulse
//            load_err         - sticky illegal-load flag
// Revision : 1.0 - initial release
// ============================================================================
interface johnson_seq_ctrl_if #(
  parameter int W      = 6,
  parameter int RATE_W = 3,
  parameter int PH_W   = 4
) ();
  logic              start;
  logic              stop;
  logic              step;
  logic              dir;
  logic [RATE_W-1:0] rate;
  logic              load;
  logic [W-1:0]      load_val;
  logic [W-1:0]      ring;
  logic [PH_W-1:0]   phase;
  logic              busy;
  logic              wrap;
  logic              load_err;

  modport master (
    output start, stop, step, dir, rate, load, load_val,
    input  ring, phase, busy, wrap, load_err
  );

  modport slave (
    input  start, stop, step, dir, rate, load, load_val,
    output ring, phase, busy, wrap, load_err
  );
endinterface
`default_nettype wire

// File: rtl/johnson_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : johnson_seq_ctrl
// Purpose  : Commandable W-stage Johnson (twisted-ring) shift register with
//            run/stop, single step, direction, programmable step rate and
//            parallel load. Reports phase index and a wrap pulse.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - johnson_seq_ctrl_if.slave (commands in, status out)
// Revision : 1.0 - initial release
// ============================================================================
module johnson_seq_ctrl #(
  parameter int W      = 6,
  parameter int RATE_W = 3,
  parameter int PH_W   = 4
) (
  input wire                clk,
  input wire                rst_n,
  johnson_seq_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [PH_W-1:0]   c_PH_LAST  = PH_W'(2 * W - 1);
  localparam logic [PH_W-1:0]   c_PH_SPAN  = PH_W'(2 * W);
  localparam logic [W-2:0]      c_EDGE_ONE = (W - 1)'(1);
  localparam logic [RATE_W-1:0] c_CNT_ONE  = RATE_W'(1);

  state_t            r_state, w_state_nxt;
  logic [W-1:0]      r_ring, w_ring_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic [RATE_W-1:0] r_count, w_count_nxt;
  logic              r_wrap, w_wrap_nxt;
  logic              r_load_err, w_load_err_nxt;
  logic              w_adv;

  logic [W-2:0]      w_edges;
  logic              w_legal;
  logic [PH_W-1:0]   w_pop;
  logic [W-1:0]      w_ring_fwd, w_ring_rev;
  logic [PH_W-1:0]   w_phase_fwd, w_phase_rev;

  // A legal Johnson pattern has at most one boundary between adjacent bits,
  // i.e. the adjacent-bit difference vector has at most one bit set.
  assign w_edges = bus.load_val[W-2:0] ^ bus.load_val[W-1:1];
  assign w_legal = ((w_edges & (w_edges - c_EDGE_ONE)) == '0);

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) begin
      w_pop = w_pop + PH_W'(bus.load_val[i]);
    end
  end

  assign w_ring_fwd  = {r_ring[W-2:0], ~r_ring[W-1]};
  assign w_ring_rev  = {~r_ring[0], r_ring[W-1:1]};
  assign w_phase_fwd = (r_phase == c_PH_LAST) ? '0 : r_phase + PH_W'(1);
  assign w_phase_rev = (r_phase == '0) ? c_PH_LAST : r_phase - PH_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_ring_nxt     = r_ring;
    w_phase_nxt    = r_phase;
    w_load_err_nxt = r_load_err;
    w_adv          = 1'b0;

    if (bus.load) begin
      // Load keeps the FSM state and suppresses any advance this cycle.
      if (w_legal) begin
        w_ring_nxt  = bus.load_val;
        // Upper half of the cycle (MSB set) counts down from 2W.
        w_phase_nxt = bus.load_val[W-1] ? (c_PH_SPAN - w_pop) : w_pop;
      end else begin
        w_ring_nxt     = '0;
        w_phase_nxt    = '0;
        w_load_err_nxt = 1'b1;
      end
      if (r_state == S_RUN) begin
        w_count_nxt = '0;
      end
    end else if (bus.stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            w_state_nxt = S_RUN;
            w_count_nxt = '0;
          end else if (bus.step) begin
            w_adv = 1'b1;
          end
        end
        S_RUN: begin
          if (r_count == bus.rate) begin
            w_adv       = 1'b1;
            w_count_nxt = '0;
          end else if (r_count > bus.rate) begin
            // Rate was lowered below the running count: resync silently.
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + c_CNT_ONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    w_wrap_nxt = w_adv & (bus.dir ? (r_phase == '0) : (r_phase == c_PH_LAST));
    if (w_adv) begin
      w_ring_nxt  = bus.dir ? w_ring_rev : w_ring_fwd;
      w_phase_nxt = bus.dir ? w_phase_rev : w_phase_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_ring     <= '0;
      r_phase    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_ring     <= w_ring_nxt;
      r_phase    <= w_phase_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign bus.ring     = r_ring;
  assign bus.phase    = r_phase;
  assign bus.busy     = (r_state == S_RUN);
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_johnson_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_johnson_seq_ctrl
// Purpose  : Scoreboard bench for johnson_seq_ctrl. The driver updates a
//            phase-based reference model and queues the expected status for
//            every clock; the monitor pops and compares after each edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_johnson_seq_ctrl;
  localparam int W      = 6;
  localparam int RATE_W = 3;
  localparam int PH_W   = 4;
  localparam int NPH    = 2 * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  johnson_seq_ctrl_if #(.W(W), .RATE_W(RATE_W), .PH_W(PH_W)) bus ();

  johnson_seq_ctrl #(.W(W), .RATE_W(RATE_W), .PH_W(PH_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [W-1:0]    ring;
    logic [PH_W-1:0] phase;
    logic            busy;
    logic            wrap;
    logic            load_err;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: position on the 2W-state cycle plus run/prescaler state.
  bit m_run;
  int m_cnt;
  int m_p;
  bit m_wrap;
  bit m_err;

  // Pattern at position p: p ones filling from bit 0, then zeros filling from bit 0.
  function automatic logic [W-1:0] ring_of(input int p);
    int v;
    if (p <= W) v = (1 << p) - 1;
    else        v = ((1 << W) - 1) & ~((1 << (p - W)) - 1);
    return v[W-1:0];
  endfunction

  function automatic int phase_of(input logic [W-1:0] v);
    for (int p = 0; p < NPH; p++) begin
      if (ring_of(p) == v) return p;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 0; m_p = 0; m_wrap = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_adv(input bit d);
    if (!d) begin
      m_wrap = (m_p == NPH - 1);
      m_p    = (m_p + 1) % NPH;
    end else begin
      m_wrap = (m_p == 0);
      m_p    = (m_p + NPH - 1) % NPH;
    end
  endtask

  task automatic cyc(input bit rn, input bit st, input bit sp, input bit stp,
                     input bit d, input int rt, input bit ld, input logic [W-1:0] lv);
    obs_t e;
    int   p;
    rst_n        = rn;
    bus.start    = st;
    bus.stop     = sp;
    bus.step     = stp;
    bus.dir      = d;
    bus.rate     = rt[RATE_W-1:0];
    bus.load     = ld;
    bus.load_val = lv;
    m_wrap = 1'b0;
    if (!rn) begin
      model_reset();
    end else if (ld) begin
      p = phase_of(lv);
      if (p >= 0) m_p = p;
      else begin m_p = 0; m_err = 1'b1; end
      if (m_run) m_cnt = 0;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (st) begin m_run = 1'b1; m_cnt = 0; end
      else if (stp) model_adv(d);
    end else begin
      if (m_cnt == rt) begin model_adv(d); m_cnt = 0; end
      else if (m_cnt > rt) m_cnt = 0;
      else m_cnt++;
    end
    e.ring     = ring_of(m_p);
    e.phase    = m_p[PH_W-1:0];
    e.busy     = m_run;
    e.wrap     = m_wrap;
    e.load_err = m_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic nop(input int n, input bit d, input int rt);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, d, rt, 1'b0, '0);
  endtask

  // Monitor: compare the presented status against the next queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = {bus.ring, bus.phase, bus.busy, bus.wrap, bus.load_err};
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL status @%0t: got ring=%b ph=%0d busy=%b wrap=%b err=%b expected ring=%b ph=%0d busy=%b wrap=%b err=%b",
                   $time, a.ring, a.phase, a.busy, a.wrap, a.load_err,
                   e.ring, e.phase, e.busy, e.wrap, e.load_err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit             rn, st, sp, stp, d, ld;
    int             rt;
    logic [W-1:0]   lv;

    bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.dir = 1'b0;
    bus.rate = '0; bus.load = 1'b0; bus.load_val = '0;
    model_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ring",  int'(bus.ring), 0);
    check("reset_phase", int'(bus.phase), 0);
    check("reset_busy",  int'(bus.busy), 0);
    check("reset_wrap",  int'(bus.wrap), 0);
    check("reset_err",   int'(bus.load_err), 0);

    // Free run forward at full rate through one complete cycle.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);
    nop(12, 1'b0, 0);
    check("run12_ring", int'(bus.ring), 0);
    check("run12_wrap", int'(bus.wrap), 1);

    // Idle single step in reverse from 000111.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 6'b000111);
    check("load_000111_phase", int'(bus.phase), 3);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, '0);
    check("step_rev_ring",  int'(bus.ring), 'b000011);
    check("step_rev_phase", int'(bus.phase), 2);
    check("step_rev_busy",  int'(bus.busy), 0);

    // Run at rate 3 (period 4), stop mid-count.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0, '0);
    nop(9, 1'b0, 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, '0);
    check("stop_busy", int'(bus.busy), 0);
    check("stop_ring", int'(bus.ring), 'b001111);
    nop(3, 1'b0, 3);
    check("frozen_phase", int'(bus.phase), 4);

    // Legal and illegal loads.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 6'b111100);
    check("load_111100_phase", int'(bus.phase), 8);
    check("load_111100_err",   int'(bus.load_err), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 6'b010100);
    check("bad_load_ring", int'(bus.ring), 0);
    check("bad_load_err",  int'(bus.load_err), 1);
    nop(3, 1'b0, 3);
    check("err_sticky", int'(bus.load_err), 1);

    // Load beats stop in RUN, then asynchronous reset mid-run.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, '0);
    nop(5, 1'b0, 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 6'b111000);
    check("load_vs_stop_busy",  int'(bus.busy), 1);
    check("load_vs_stop_phase", int'(bus.phase), 9);
    nop(1, 1'b1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ring",  int'(bus.ring), 0);
    check("async_rst_phase", int'(bus.phase), 0);
    check("async_rst_busy",  int'(bus.busy), 0);
    check("async_rst_err",   int'(bus.load_err), 0);
    model_reset();
    @(negedge clk);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);

    // Randomized command traffic.
    rt = 0;
    for (int i = 0; i < 400; i++) begin
      rn  = ($urandom_range(0, 99) != 0);
      ld  = ($urandom_range(0, 15) == 0);
      sp  = ($urandom_range(0, 15) == 0);
      st  = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) rt = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) lv = ring_of($urandom_range(0, NPH - 1));
      else                           lv = W'($urandom);
      cyc(rn, st, sp, stp, d, rt, ld, lv);
    end

    nop(2, 1'b0, 0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
